// File: rtl/sda_pkg.sv
// Shared definitions for the 4-bit serial-data link (transmitter and matching receiver).
package sda_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        BIT_L,
        BIT_H,
        STP_L,
        STP_H,
        STOP
    } sda_state_e;

    localparam int FRAME_STEPS = 12;
    localparam int NIB_W       = 4;
    localparam int DIV_W       = 8;

    // Line levels {scl, sda} held for the whole of a step in the given state.
    function automatic logic [1:0] line_lvl(sda_state_e st, logic bit_v);
        logic [1:0] lv;
        case (st)
            START:   lv = 2'b10;
            BIT_L:   lv = {1'b0, bit_v};
            BIT_H:   lv = {1'b1, bit_v};
            STP_L:   lv = 2'b00;
            STP_H:   lv = 2'b10;
            default: lv = 2'b11;
        endcase
        return lv;
    endfunction

endpackage

// File: rtl/sda_send4_if.sv
// Request/line bundle between a nibble source and the serial transmitter.
interface sda_send4_if;
    import sda_pkg::*;

    logic             send;
    logic [NIB_W-1:0] data;
    logic             scl;
    logic             sda;
    logic             busy;
    logic             done;

    modport master (output send, data, input  scl, sda, busy, done);
    modport slave  (input  send, data, output scl, sda, busy, done);

endinterface

// File: rtl/sda_step_tick.sv
// Bus-step divider: counts 0..DIV-1 and flags the last cycle of each step.
module sda_step_tick
    import sda_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/sda_send4.sv
// Serial transmitter: START, four MSB-first bits (low/high half each), stop preamble, STOP.
module sda_send4
    import sda_pkg::*;
#(
    parameter int DIV = 1
) (
    input logic        clk,
    input logic        rst,
    sda_send4_if.slave bus
);

    sda_state_e       state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [NIB_W-1:0] nib_q, nib_d;
    logic             scl_q, scl_d;
    logic             sda_q, sda_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tick;
    logic             accept;
    logic             div_rst;

    // Holding the divider cleared while idle aligns every step to the accepting edge.
    assign div_rst = rst | (state_q == IDLE);

    sda_step_tick #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (div_rst),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        nib_d   = nib_q;
        accept  = 1'b0;
        case (state_q)
            IDLE:  accept = bus.send;
            START: if (tick) state_d = BIT_L;
            BIT_L: if (tick) state_d = BIT_H;
            BIT_H: if (tick) begin
                if (idx_q == 2'd0) begin
                    state_d = STP_L;
                end else begin
                    state_d = BIT_L;
                    idx_d   = idx_q - 2'd1;
                end
            end
            STP_L: if (tick) state_d = STP_H;
            STP_H: if (tick) state_d = STOP;
            // The last cycle of STOP counts as idle so back-to-back frames lose no step.
            STOP:  if (tick) begin
                if (bus.send) accept  = 1'b1;
                else          state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            state_d = START;
            nib_d   = bus.data;
            idx_d   = 2'd3;
        end
        {scl_d, sda_d} = line_lvl(state_d, nib_d[idx_d]);
        busy_d         = (state_d != IDLE);
        done_d         = (state_d == STOP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd3;
            nib_q   <= '0;
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            nib_q   <= nib_d;
            scl_q   <= scl_d;
            sda_q   <= sda_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.scl  = scl_q;
    assign bus.sda  = sda_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule
